// File: rtl/cart_pkg.sv
// Shared types, widths and slot packing layout for the sale-terminal cart controller.
package cart_pkg;

  localparam int unsigned N_ITEMS = 12;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned PRICE_W = 16;
  localparam int unsigned TOTAL_W = 20;
  localparam int unsigned ACC_W   = 24;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned SLOT_W  = CNT_W + PRICE_W;
  localparam int unsigned PROD_W  = CNT_W + PRICE_W;
  localparam int unsigned NUM_W   = N_ITEMS * SLOT_W;

  // Field offsets inside one packed slot {count, price}
  localparam int unsigned SLOT_PRICE_LSB = 0;
  localparam int unsigned SLOT_CNT_LSB   = PRICE_W;

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

  typedef enum logic [OP_W-1:0] {
    OP_ADD       = 2'd0,
    OP_REMOVE    = 2'd1,
    OP_CLEAR     = 2'd2,
    OP_SET_PRICE = 2'd3
  } cart_op_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_APPLY      = 3'd1,
    ST_SUM        = 3'd2,
    ST_WAIT_FRAME = 3'd3,
    ST_PUBLISH    = 3'd4
  } cart_state_e;

  typedef struct packed {
    cart_op_e           op;
    logic [IDX_W-1:0]   slot;
    logic [PRICE_W-1:0] price;
  } cart_cmd_t;

  typedef struct packed {
    logic [CNT_W-1:0]   count;
    logic [PRICE_W-1:0] price;
  } cart_slot_t;

  // MSB position of slot i in the published numbers bus (slot 0 at the top)
  function automatic int unsigned slot_msb(input int unsigned i);
    return NUM_W - 1 - SLOT_W * i;
  endfunction

endpackage

// File: rtl/cart_mac.sv
// Registered multiply-accumulate with synchronous clear and a saturated, registered result.
module cart_mac
  import cart_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [CNT_W-1:0]   count_i,
  input  logic [PRICE_W-1:0] price_i,
  output logic [TOTAL_W-1:0] result_o
);

  logic [PROD_W-1:0]  prod;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [TOTAL_W-1:0] result_q, result_d;

  always_comb begin
    prod = PROD_W'(count_i) * PROD_W'(price_i);
  end

  // Clear wins over enable so a new sum always starts from zero
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
    result_d = (acc_d > ACC_W'(TOTAL_MAX)) ? TOTAL_MAX : acc_d[TOTAL_W-1:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/cart_controller.sv
// Cart slot store, command FSM and serial total recompute feeding price_writer.
// CART_FRAME_SYNC_EN: hold publish until the next frame_start pulse (tear-free display).
module cart_controller
  import cart_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [IDX_W-1:0]   cmd_slot,
  input  logic [PRICE_W-1:0] cmd_price,
  input  logic               frame_start,
  output logic [NUM_W-1:0]   numbers,
  output logic [TOTAL_W-1:0] total_price,
  output logic               busy,
  output logic               err
);

  cart_state_e        state_q, state_d;
  cart_cmd_t          cmd_q, cmd_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  cart_slot_t         slots_q [N_ITEMS];
  cart_slot_t         slots_d [N_ITEMS];
  logic [NUM_W-1:0]   numbers_q, numbers_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;

  logic               slot_ok;
  logic [CNT_W-1:0]   slot_count;
  logic               cmd_bad;
  logic [NUM_W-1:0]   packed_slots;
  logic               mac_clr, mac_en;
  logic [TOTAL_W-1:0] mac_result;

`ifndef CART_FRAME_SYNC_EN
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

  // Legality of the incoming command, judged against the current slot array
  always_comb begin
    slot_ok    = (cmd_slot < IDX_W'(N_ITEMS));
    slot_count = slot_ok ? slots_q[cmd_slot].count : '0;
    cmd_bad    = 1'b0;
    if (cart_op_e'(cmd_op) != OP_CLEAR) begin
      if (!slot_ok) begin
        cmd_bad = 1'b1;
      end else if (cart_op_e'(cmd_op) == OP_ADD && slot_count == CNT_MAX) begin
        cmd_bad = 1'b1;
      end else if (cart_op_e'(cmd_op) == OP_REMOVE && slot_count == '0) begin
        cmd_bad = 1'b1;
      end
    end
  end

  always_comb begin
    packed_slots = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      packed_slots[slot_msb(i) -: SLOT_W] = slots_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    idx_d     = idx_q;
    slots_d   = slots_q;
    numbers_d = numbers_q;
    total_d   = total_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    ready_d   = ready_q;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          cmd_d.op    = cart_op_e'(cmd_op);
          cmd_d.slot  = cmd_slot;
          cmd_d.price = cmd_price;
          err_d       = cmd_bad;
          busy_d      = 1'b1;
          ready_d     = 1'b0;
          state_d     = ST_APPLY;
        end
      end
      // err_q is high exactly in this cycle for a rejected command
      ST_APPLY: begin
        if (err_q) begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          case (cmd_q.op)
            OP_ADD:    slots_d[cmd_q.slot].count = slots_q[cmd_q.slot].count + CNT_W'(1);
            OP_REMOVE: slots_d[cmd_q.slot].count = slots_q[cmd_q.slot].count - CNT_W'(1);
            OP_CLEAR: begin
              for (int i = 0; i < N_ITEMS; i++) begin
                slots_d[i].count = '0;
              end
            end
            OP_SET_PRICE: slots_d[cmd_q.slot].price = cmd_q.price;
            default: ;
          endcase
          mac_clr = 1'b1;
          idx_d   = '0;
          state_d = ST_SUM;
        end
      end
      ST_SUM: begin
        mac_en = 1'b1;
        if (idx_q == IDX_W'(N_ITEMS - 1)) begin
`ifdef CART_FRAME_SYNC_EN
          state_d = ST_WAIT_FRAME;
`else
          state_d = ST_PUBLISH;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
`ifdef CART_FRAME_SYNC_EN
      ST_WAIT_FRAME: begin
        if (frame_start) begin
          state_d = ST_PUBLISH;
        end
      end
`endif
      ST_PUBLISH: begin
        numbers_d = packed_slots;
        total_d   = mac_result;
        busy_d    = 1'b0;
        ready_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      idx_q     <= '0;
      slots_q   <= '{default: '0};
      numbers_q <= '0;
      total_q   <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      idx_q     <= idx_d;
      slots_q   <= slots_d;
      numbers_q <= numbers_d;
      total_q   <= total_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  cart_mac u_mac (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clr_i    (mac_clr),
    .en_i     (mac_en),
    .count_i  (slots_q[idx_q].count),
    .price_i  (slots_q[idx_q].price),
    .result_o (mac_result)
  );

  assign cmd_ready   = ready_q;
  assign numbers     = numbers_q;
  assign total_price = total_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cart_controller.sv
// Directed bench for cart_controller; works with or without CART_FRAME_SYNC_EN.
module tb_cart_controller;

  logic         CLK;
  logic         RST_N;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [3:0]   cmd_slot;
  logic [15:0]  cmd_price;
  logic         frame_start;
  logic [239:0] numbers;
  logic [19:0]  total_price;
  logic         busy;
  logic         err;

  int checks   = 0;
  int failures = 0;

  int mcnt [12];
  int mprc [12];

  logic last_err;
  int   last_lat;
  int   err_hits;
  int   low_cycles;

  localparam logic [1:0] ADD = 2'd0, REM = 2'd1, CLR = 2'd2, SETP = 2'd3;

  cart_controller dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_slot    (cmd_slot),
    .cmd_price   (cmd_price),
    .frame_start (frame_start),
    .numbers     (numbers),
    .total_price (total_price),
    .busy        (busy),
    .err         (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [239:0] obs, input logic [239:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [239:0] model_numbers();
    logic [239:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) begin
      r[239-20*i -: 20] = {4'(mcnt[i]), 16'(mprc[i])};
    end
    return r;
  endfunction

  function automatic logic [19:0] model_total();
    longint s;
    s = 0;
    for (int i = 0; i < 12; i++) s += longint'(mcnt[i]) * longint'(mprc[i]);
    return (s > 64'hFFFFF) ? 20'hFFFFF : 20'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin
      mcnt[i] = 0;
      mprc[i] = 0;
    end
  endtask

  // Wait on negedges until busy drops; frame pulse supplied late in sync builds
  task automatic wait_idle(output int lat, output logic saw_err);
    lat = 0;
    saw_err = 1'b0;
    while (lat < 300) begin
      @(negedge CLK);
      lat++;
      if (err) saw_err = 1'b1;
`ifdef CART_FRAME_SYNC_EN
      frame_start = (lat == 20);
`endif
      if (!busy) break;
    end
    frame_start = 1'b0;
    if (busy) check_eq("busy_timeout", 240'(busy), 240'(0));
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge CLK);
    while (!cmd_ready && guard < 300) begin
      @(negedge CLK);
      guard++;
    end
    if (!cmd_ready) check_eq("ready_timeout", 240'(cmd_ready), 240'(1));
  endtask

  task automatic run_cmd(input logic [1:0] op, input int slot, input int price);
    logic bad;
    bad = 1'b0;
    if (op != CLR) begin
      if (slot >= 12) bad = 1'b1;
      else if (op == ADD && mcnt[slot] == 15) bad = 1'b1;
      else if (op == REM && mcnt[slot] == 0) bad = 1'b1;
    end
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_slot  = 4'(slot);
    cmd_price = 16'(price);
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    wait_idle(last_lat, last_err);
    if (!bad) begin
      case (op)
        ADD:  mcnt[slot]++;
        REM:  mcnt[slot]--;
        CLR:  for (int i = 0; i < 12; i++) mcnt[i] = 0;
        default: mprc[slot] = price;
      endcase
    end
  endtask

  initial begin
    logic d_err;
    int   d_lat;
    RST_N = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_slot = '0;
    cmd_price = '0;
    frame_start = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    check_eq("rst_numbers", numbers, 240'(0));
    check_eq("rst_total", 240'(total_price), 240'(0));
    check_eq("rst_ready", 240'(cmd_ready), 240'(1));
    check_eq("rst_busy", 240'(busy), 240'(0));
    check_eq("rst_err", 240'(err), 240'(0));

    run_cmd(SETP, 0, 250);
    repeat (3) run_cmd(ADD, 0, 0);
    check_eq("slot0_field", 240'(numbers[239:220]), 240'({4'd3, 16'd250}));
    check_eq("total_750", 240'(total_price), 240'(750));
    check_eq("busy_after_pub", 240'(busy), 240'(0));
`ifndef CART_FRAME_SYNC_EN
    check_eq("latency", 240'(last_lat), 240'(15));
`endif

    run_cmd(SETP, 5, 1000);
    run_cmd(ADD, 5, 0);
    run_cmd(ADD, 5, 0);
    check_eq("total_2750", 240'(total_price), 240'(2750));
    check_eq("numbers_mix", numbers, model_numbers());

    err_hits = 0;
    for (int k = 0; k < 16; k++) begin
      run_cmd(ADD, 2, 0);
      if (last_err) err_hits++;
    end
    check_eq("add_sat_errs", 240'(err_hits), 240'(1));
    check_eq("add_sat_last_err", 240'(last_err), 240'(1));
    check_eq("slot2_field", 240'(numbers[199:180]), 240'({4'd15, 16'd0}));

    run_cmd(REM, 7, 0);
    check_eq("rem_empty_err", 240'(last_err), 240'(1));
    check_eq("rem_empty_lat", 240'(last_lat), 240'(2));
    check_eq("rem_empty_numbers", numbers, model_numbers());
    run_cmd(ADD, 12, 0);
    check_eq("bad_slot_err", 240'(last_err), 240'(1));
    check_eq("bad_slot_total", 240'(total_price), 240'(2750));

    for (int s = 0; s < 12; s++) begin
      run_cmd(SETP, s, 16'hFFFF);
      while (mcnt[s] < 15) run_cmd(ADD, s, 0);
    end
    check_eq("sat_total", 240'(total_price), 240'(20'hFFFFF));
    check_eq("sat_model_total", 240'(total_price), 240'(model_total()));
    check_eq("sat_numbers", numbers, model_numbers());

    run_cmd(CLR, 0, 0);
    check_eq("clear_total", 240'(total_price), 240'(0));
    check_eq("clear_slot11", 240'(numbers[19:0]), 240'({4'd0, 16'hFFFF}));
    check_eq("clear_numbers", numbers, model_numbers());

    // Command held valid while the block is busy
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = ADD;
    cmd_slot = 4'd1;
    cmd_price = '0;
    @(posedge CLK);
    #1;
    cmd_op = SETP;
    cmd_price = 16'd77;
    low_cycles = 0;
    @(negedge CLK);
    while (!cmd_ready && low_cycles < 300) begin
      low_cycles++;
`ifdef CART_FRAME_SYNC_EN
      frame_start = (low_cycles == 20);
`endif
      @(negedge CLK);
    end
    frame_start = 1'b0;
`ifndef CART_FRAME_SYNC_EN
    check_eq("held_ready_low", 240'(low_cycles), 240'(14));
`endif
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    @(negedge CLK);
    check_eq("held_accept_busy", 240'(busy), 240'(1));
    wait_idle(d_lat, d_err);
    mcnt[1] = 1;
    mprc[1] = 77;
    check_eq("held_total", 240'(total_price), 240'(77));
    check_eq("held_numbers", numbers, model_numbers());

`ifdef CART_FRAME_SYNC_EN
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = ADD;
    cmd_slot = 4'd6;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    repeat (13) @(negedge CLK);
    frame_start = 1'b1;
    @(negedge CLK);
    frame_start = 1'b0;
    repeat (10) @(negedge CLK);
    check_eq("sync_late_pulse_busy", 240'(busy), 240'(1));
    check_eq("sync_hold_total", 240'(total_price), 240'(77));
    frame_start = 1'b1;
    @(negedge CLK);
    frame_start = 1'b0;
    wait_idle(d_lat, d_err);
    mcnt[6] = 1;
    check_eq("sync_publish_total", 240'(total_price), 240'(model_total()));
`endif

    // Asynchronous reset in the middle of SUM
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = ADD;
    cmd_slot = 4'd3;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    repeat (5) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_eq("midrst_numbers", numbers, 240'(0));
    check_eq("midrst_total", 240'(total_price), 240'(0));
    check_eq("midrst_busy", 240'(busy), 240'(0));
    check_eq("midrst_ready", 240'(cmd_ready), 240'(1));
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();

    run_cmd(SETP, 4, 10);
    run_cmd(ADD, 4, 0);
    check_eq("post_rst_total", 240'(total_price), 240'(10));
    check_eq("post_rst_numbers", numbers, model_numbers());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
